// File: rtl/ifu_pc_gen_pkg.sv
// rtl/ifu_pc_gen_pkg.sv - shared widths, reset PC and FSM state encoding for the fetch PC generator
package ifu_pc_gen_pkg;

  localparam int          E203_PC_SIZE  = 32;
  localparam logic [31:0] E203_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    PCG_REQ  = 2'd0,
    PCG_WAIT = 2'd1,
    PCG_DEC  = 2'd2
  } pcg_state_e;

endpackage

// File: rtl/ifu_pc_gen_if.sv
// rtl/ifu_pc_gen_if.sv - instruction fetch request/response handshake bundle
interface ifu_pc_gen_if
  import ifu_pc_gen_pkg::*;
#(
  parameter int PC_SIZE = E203_PC_SIZE
);

  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [PC_SIZE-1:0] ifu_req_pc;
  logic               ifu_rsp_valid;
  logic               ifu_rsp_ready;

  // Fetch controller side
  modport master (
    output ifu_req_valid,
    input  ifu_req_ready,
    output ifu_req_pc,
    input  ifu_rsp_valid,
    output ifu_rsp_ready
  );

  // Instruction memory side
  modport slave (
    input  ifu_req_valid,
    output ifu_req_ready,
    input  ifu_req_pc,
    output ifu_rsp_valid,
    input  ifu_rsp_ready
  );

endinterface

// File: rtl/ifu_nxtpc_add.sv
// rtl/ifu_nxtpc_add.sv - next fetch PC: predicted target or sequential +2/+4
module ifu_nxtpc_add
  import ifu_pc_gen_pkg::*;
#(
  parameter int PC_SIZE = E203_PC_SIZE
) (
  input  logic [PC_SIZE-1:0] pc,
  input  logic               is_16bit,
  input  logic               taken,
  input  logic [PC_SIZE-1:0] op1,
  input  logic [PC_SIZE-1:0] op2,
  output logic [PC_SIZE-1:0] nxt_pc
);

  logic [PC_SIZE-1:0] tgt_sum;
  logic [PC_SIZE-1:0] seq_inc;

  // Both additions simply wrap at PC_SIZE bits; the target always lands on a halfword.
  assign tgt_sum = op1 + op2;
  assign seq_inc = is_16bit ? PC_SIZE'(2) : PC_SIZE'(4);
  assign nxt_pc  = taken ? {tgt_sum[PC_SIZE-1:1], 1'b0} : (pc + seq_inc);

endmodule

// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - fetch PC holder and single-outstanding fetch request controller
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter int               PC_SIZE  = E203_PC_SIZE,
  parameter logic [PC_SIZE-1:0] RESET_PC = E203_RESET_PC[PC_SIZE-1:0]
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_SIZE-1:0] pc,
  ifu_pc_gen_if.master       ifu,
  output logic               dec_i_valid,
  input  logic               dec_is_16bit,
  input  logic               prdt_taken,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  logic               bpu_wait,
  input  logic               ir_ready,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_pc,
  output logic               pipe_flush_ack
);

  pcg_state_e         state;
  pcg_state_e         state_nxt;
  logic [PC_SIZE-1:0] pc_nxt;
  logic [PC_SIZE-1:0] nxt_pc;
  logic [PC_SIZE-1:0] flush_tgt;
  logic               flush_pend;
  logic               flush_pend_nxt;
  logic               hs;

  ifu_nxtpc_add #(.PC_SIZE(PC_SIZE)) u_nxtpc_add (
    .pc       (pc),
    .is_16bit (dec_is_16bit),
    .taken    (prdt_taken),
    .op1      (prdt_pc_add_op1),
    .op2      (prdt_pc_add_op2),
    .nxt_pc   (nxt_pc)
  );

  assign flush_tgt      = {pipe_flush_pc[PC_SIZE-1:1], 1'b0};
  assign hs             = ir_ready & ~bpu_wait;
  assign ifu.ifu_req_pc = pc;

  // State, fetch PC and pending-discard flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PCG_REQ;
      pc         <= RESET_PC;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  // Next state: a flush outranks every other event; an in-flight request is marked for discard
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    flush_pend_nxt = flush_pend;
    case (state)
      PCG_REQ: begin
        if (pipe_flush_req) begin
          pc_nxt = flush_tgt;
          if (ifu.ifu_req_ready) begin
            state_nxt      = PCG_WAIT;
            flush_pend_nxt = 1'b1;
          end
        end else if (ifu.ifu_req_ready) begin
          state_nxt = PCG_WAIT;
        end
      end
      PCG_WAIT: begin
        if (ifu.ifu_rsp_valid && flush_pend) begin
          state_nxt      = PCG_REQ;
          flush_pend_nxt = 1'b0;
          if (pipe_flush_req) begin
            pc_nxt = flush_tgt;
          end
        end else if (pipe_flush_req) begin
          pc_nxt         = flush_tgt;
          flush_pend_nxt = 1'b1;
        end else if (ifu.ifu_rsp_valid) begin
          state_nxt = PCG_DEC;
        end
      end
      PCG_DEC: begin
        if (pipe_flush_req) begin
          pc_nxt    = flush_tgt;
          state_nxt = PCG_REQ;
        end else if (hs) begin
          pc_nxt    = nxt_pc;
          state_nxt = PCG_REQ;
        end
      end
      default: begin
        state_nxt = PCG_REQ;
      end
    endcase
  end

  // Handshake outputs; everything is held low while reset is asserted
  always_comb begin
    ifu.ifu_req_valid = 1'b0;
    ifu.ifu_rsp_ready = 1'b0;
    dec_i_valid       = 1'b0;
    pipe_flush_ack    = 1'b0;
    if (!rst) begin
      pipe_flush_ack = pipe_flush_req;
      case (state)
        PCG_REQ:  ifu.ifu_req_valid = 1'b1;
        PCG_WAIT: ifu.ifu_rsp_ready = ifu.ifu_rsp_valid & flush_pend;
        PCG_DEC: begin
          dec_i_valid       = 1'b1;
          ifu.ifu_rsp_ready = hs | pipe_flush_req;
        end
        default: ;
      endcase
    end
  end

endmodule
